// File: rtl/dpe_mux_arb_n.sv
// N-input AXI-Stream packet multiplexer: whole-packet grants, round-robin or fixed-priority
// arbitration, per-channel enable, drain-then-stop pause, and a 2-entry registered skid output.
module dpe_mux_arb_n #(
  parameter int NUM_CH      = 5,
  parameter int TDATA_WIDTH = 128,
  parameter int TUSER_WIDTH = 5,
  parameter int ARB_MODE    = 0,
  parameter int ID_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pause,
  output logic                            paused,
  input  logic [NUM_CH-1:0]               ch_enable,
  input  logic [NUM_CH*TDATA_WIDTH-1:0]   in_tdata,
  input  logic [NUM_CH*TDATA_WIDTH/8-1:0] in_tkeep,
  input  logic [NUM_CH*TUSER_WIDTH-1:0]   in_tuser,
  input  logic [NUM_CH-1:0]               in_tlast,
  input  logic [NUM_CH-1:0]               in_tvalid,
  output logic [NUM_CH-1:0]               in_tready,
  output logic [TDATA_WIDTH-1:0]          out_tdata,
  output logic [TDATA_WIDTH/8-1:0]        out_tkeep,
  output logic [TUSER_WIDTH-1:0]          out_tuser,
  output logic                            out_tlast,
  output logic [ID_W-1:0]                 out_tid,
  output logic                            out_tvalid,
  input  logic                            out_tready,
  output logic [15:0]                     pkt_count
);

  localparam int KW = TDATA_WIDTH / 8;
  localparam int EW = TDATA_WIDTH + KW + TUSER_WIDTH + 1 + ID_W;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q;
  logic [ID_W-1:0] grant_q, ptr_q;
  logic            paused_q;
  logic [15:0]     pkt_count_q;
  logic [1:0]      cnt_q, cnt_d;
  logic [EW-1:0]   e0_q, e0_d, e1_q, e1_d;

  logic [TDATA_WIDTH-1:0] ch_data [NUM_CH];
  logic [KW-1:0]          ch_keep [NUM_CH];
  logic [TUSER_WIDTH-1:0] ch_user [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign ch_data[c] = in_tdata[c*TDATA_WIDTH +: TDATA_WIDTH];
    assign ch_keep[c] = in_tkeep[c*KW +: KW];
    assign ch_user[c] = in_tuser[c*TUSER_WIDTH +: TUSER_WIDTH];
  end

  logic [NUM_CH-1:0] req;
  logic              arb_hit;
  logic [ID_W-1:0]   arb_idx;
  logic [ID_W-1:0]   ptr_inc;

  assign req     = in_tvalid & ch_enable;
  assign ptr_inc = (grant_q == ID_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;

  // Search order starts at the RR pointer (mode 0) or at channel 0 (mode 1).
  always_comb begin
    int c;
    arb_hit = 1'b0;
    arb_idx = '0;
    c       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = (ARB_MODE == 1) ? i : (int'(ptr_q) + i) % NUM_CH;
      if (!arb_hit && req[c]) begin
        arb_hit = 1'b1;
        arb_idx = ID_W'(c);
      end
    end
  end

  logic          full, empty, ready_g, push, pop;
  logic [EW-1:0] beat_in;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign ready_g = (state_q == GRANT) && !full;
  assign push    = ready_g && in_tvalid[grant_q];
  assign pop     = !empty && out_tready;
  assign beat_in = {ch_data[grant_q], ch_keep[grant_q], ch_user[grant_q], in_tlast[grant_q], grant_q};

  always_comb begin
    in_tready = '0;
    if (ready_g) in_tready[grant_q] = 1'b1;
  end

  // Head entry e0 drives the outputs directly, so the output is fully registered.
  always_comb begin
    cnt_d = cnt_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    case ({push, pop})
      2'b10: begin
        if (empty) e0_d = beat_in;
        else       e1_d = beat_in;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          e0_d = beat_in;
        end else begin
          e0_d = e1_q;
          e1_d = beat_in;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      paused_q    <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      paused_q <= pause && (state_q == IDLE) && empty;
      if (pop && e0_q[ID_W]) pkt_count_q <= pkt_count_q + 16'd1;
      case (state_q)
        IDLE: begin
          if (!pause && arb_hit) begin
            grant_q <= arb_idx;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (push && in_tlast[grant_q]) begin
            state_q <= IDLE;
            if (ARB_MODE == 0) ptr_q <= ptr_inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {out_tdata, out_tkeep, out_tuser, out_tlast, out_tid} = e0_q;
  assign out_tvalid = !empty;
  assign paused     = paused_q;
  assign pkt_count  = pkt_count_q;

endmodule
